// File: rtl/gamepad_poller.sv
// Serial SNES-style gamepad poller: drives shared latch/clock lines, shifts in one data bit per
// port per pad_clk period and publishes a coherent snapshot with a one-cycle valid strobe.
module gamepad_poller #(
  parameter int unsigned PORTS           = 4,
  parameter int unsigned SHIFT_BITS      = 16,
  parameter int unsigned HALF_PERIOD     = 2,
  parameter int unsigned POLL_PERIOD     = 200000,
  parameter bit          DATA_ACTIVE_LOW = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          poll_req,
  input  logic                          auto_enable,
  input  logic [PORTS-1:0]              pad_data,
  output logic                          pad_latch,
  output logic                          pad_clk,
  output logic [PORTS*SHIFT_BITS-1:0]   pad_btn,
  output logic                          pad_valid,
  output logic                          busy
);

  localparam int unsigned CntW = $clog2(2 * HALF_PERIOD);
  localparam int unsigned BitW = (SHIFT_BITS > 1) ? $clog2(SHIFT_BITS) : 1;
  localparam int unsigned TmrW = $clog2(POLL_PERIOD);

  localparam logic [CntW-1:0] CntLast    = CntW'(2 * HALF_PERIOD - 1);
  localparam logic [CntW-1:0] CntLowLast = CntW'(HALF_PERIOD - 1);
  localparam logic [BitW-1:0] BitLast    = BitW'(SHIFT_BITS - 1);
  localparam logic [TmrW-1:0] TmrLast    = TmrW'(POLL_PERIOD - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StLatch = 2'd1;
  localparam logic [1:0] StShift = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [BitW-1:0]       bit_q, bit_d;
  logic [TmrW-1:0]       timer_q, timer_d;
  logic                  pending_q, pending_d;
  logic [SHIFT_BITS-1:0] buf_q [PORTS];
  logic [SHIFT_BITS-1:0] buf_d [PORTS];

  logic                        pad_latch_q, pad_latch_d;
  logic                        pad_clk_q, pad_clk_d;
  logic [PORTS*SHIFT_BITS-1:0] pad_btn_q, pad_btn_d;
  logic                        pad_valid_q, pad_valid_d;
  logic                        busy_q, busy_d;

  logic auto_req;
  logic req;

  always_comb begin
    timer_d  = timer_q;
    auto_req = 1'b0;
    if (!auto_enable) begin
      timer_d = '0;
    end else if (timer_q == TmrLast) begin
      timer_d  = '0;
      auto_req = 1'b1;
    end else begin
      timer_d = timer_q + TmrW'(1);
    end
  end

  // External and auto requests in the same cycle merge into one.
  assign req = poll_req | auto_req;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    pending_d = pending_q;
    buf_d     = buf_q;
    case (state_q)
      StIdle, StDone: begin
        if (req || pending_q) begin
          state_d   = StLatch;
          cnt_d     = '0;
          pending_d = 1'b0;
        end else begin
          state_d = StIdle;
        end
      end
      StLatch: begin
        if (req) pending_d = 1'b1;
        if (cnt_q == CntLast) begin
          state_d = StShift;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StShift: begin
        if (req) pending_d = 1'b1;
        // Sample at the end of the low phase, when pad data has had longest to settle.
        if (cnt_q == CntLowLast) begin
          for (int p = 0; p < PORTS; p++) begin
            buf_d[p][bit_q] = pad_data[p] ^ DATA_ACTIVE_LOW;
          end
        end
        if (cnt_q == CntLast) begin
          cnt_d = '0;
          if (bit_q == BitLast) state_d = StDone;
          else                  bit_d   = bit_q + BitW'(1);
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from next-state so they align with the state they describe.
  always_comb begin
    pad_latch_d = (state_d == StLatch);
    pad_clk_d   = !((state_d == StShift) && (cnt_d <= CntLowLast));
    pad_valid_d = (state_d == StDone);
    busy_d      = (state_d != StIdle);
    pad_btn_d   = pad_btn_q;
    if (state_d == StDone) begin
      for (int p = 0; p < PORTS; p++) begin
        pad_btn_d[p*SHIFT_BITS +: SHIFT_BITS] = buf_d[p];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_q       <= '0;
      timer_q     <= '0;
      pending_q   <= 1'b0;
      for (int p = 0; p < PORTS; p++) buf_q[p] <= '0;
      pad_latch_q <= 1'b0;
      pad_clk_q   <= 1'b1;
      pad_btn_q   <= '0;
      pad_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      timer_q     <= timer_d;
      pending_q   <= pending_d;
      for (int p = 0; p < PORTS; p++) buf_q[p] <= buf_d[p];
      pad_latch_q <= pad_latch_d;
      pad_clk_q   <= pad_clk_d;
      pad_btn_q   <= pad_btn_d;
      pad_valid_q <= pad_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign pad_latch = pad_latch_q;
  assign pad_clk   = pad_clk_q;
  assign pad_btn   = pad_btn_q;
  assign pad_valid = pad_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_gamepad_poller.sv
// Directed bench for gamepad_poller: a behavioural SNES pad on port 0 of the main instance and a
// second active-high, narrow instance for the polarity case.
module tb_gamepad_poller;

  logic        clk = 1'b0;
  logic        reset;
  logic        poll_req, poll_req2;
  logic        auto_enable;
  logic [3:0]  pad_data;
  logic        pad_latch, pad_clk, pad_valid, busy;
  logic [63:0] pad_btn;
  logic        pad_latch2, pad_clk2, pad_valid2, busy2;
  logic [23:0] pad_btn2;

  int checks = 0;
  int errors = 0;

  logic [15:0] pad_val = 16'hFFFF;
  logic [15:0] sr = 16'hFFFF;
  logic        pclk = 1'b1;

  always #5 clk = ~clk;

  gamepad_poller #(.POLL_PERIOD(200)) dut (
    .clk(clk), .reset(reset), .poll_req(poll_req), .auto_enable(auto_enable),
    .pad_data(pad_data), .pad_latch(pad_latch), .pad_clk(pad_clk), .pad_btn(pad_btn),
    .pad_valid(pad_valid), .busy(busy)
  );

  gamepad_poller #(
    .PORTS(2), .SHIFT_BITS(12), .POLL_PERIOD(200), .DATA_ACTIVE_LOW(1'b0)
  ) dut2 (
    .clk(clk), .reset(reset), .poll_req(poll_req2), .auto_enable(1'b0),
    .pad_data(2'b11), .pad_latch(pad_latch2), .pad_clk(pad_clk2), .pad_btn(pad_btn2),
    .pad_valid(pad_valid2), .busy(busy2)
  );

  // Pad model for port 0: parallel load while latched, shift on each pad_clk rising edge.
  always @(posedge clk) begin
    #1;
    if (pad_latch) sr = pad_val;
    else if (pad_clk && !pclk) sr = {1'b1, sr[15:1]};
    pclk = pad_clk;
  end
  assign pad_data = {3'b111, sr[0]};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".latch"}, 64'(pad_latch), 64'd0);
    check({tag, ".clk"},   64'(pad_clk),   64'd1);
    check({tag, ".btn"},   pad_btn,        64'd0);
    check({tag, ".valid"}, 64'(pad_valid), 64'd0);
    check({tag, ".busy"},  64'(busy),      64'd0);
  endtask

  // Issue one request and follow the poll; lat = edges from request edge to pad_valid.
  task automatic run_poll(output int lat, output int nlatch, output int nfall, output int nlow);
    logic prev;
    lat = -1; nlatch = 0; nfall = 0; nlow = 0;
    poll_req = 1'b1;
    tick();
    poll_req = 1'b0;
    check("poll.start_latch", 64'(pad_latch), 64'd1);
    check("poll.start_busy",  64'(busy),      64'd1);
    nlatch = 1;
    prev = pad_clk;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (pad_latch) nlatch++;
      if (!pad_clk) nlow++;
      if (prev && !pad_clk) nfall++;
      prev = pad_clk;
      if (pad_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic wait_rise(input int limit, output int n);
    logic prev;
    n = -1;
    prev = pad_latch;
    for (int k = 1; k <= limit; k++) begin
      tick();
      if (pad_latch && !prev) begin
        n = k;
        break;
      end
      prev = pad_latch;
    end
  endtask

  task automatic wait_valid(input int limit);
    for (int k = 0; k < limit; k++) begin
      tick();
      if (pad_valid) break;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nl, nf, nlow, n, nv, v1, r2;
    logic prev;
    reset = 1'b1; poll_req = 1'b1; poll_req2 = 1'b0; auto_enable = 1'b0;

    // Reset held with a pending request must win.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_reset_outputs("reset");
    end
    check("reset.btn2", 64'(pad_btn2), 64'd0);
    reset = 1'b0; poll_req = 1'b0;
    repeat (5) tick();
    check("reset.no_poll_busy",  64'(busy),      64'd0);
    check("reset.no_poll_latch", 64'(pad_latch), 64'd0);

    // Single poll with defaults.
    pad_val = ~16'hA5F0;
    run_poll(lat, nl, nf, nlow);
    check("single.latency",   64'(lat),  64'd68);
    check("single.latch_len", 64'(nl),   64'd4);
    check("single.clk_falls", 64'(nf),   64'd16);
    check("single.clk_low",   64'(nlow), 64'd32);
    check("single.btn0",      64'(pad_btn[15:0]),  64'h0000_0000_0000_A5F0);
    check("single.btn_hi",    64'(pad_btn[63:16]), 64'd0);
    tick();
    check("single.valid_1cyc", 64'(pad_valid), 64'd0);
    check("single.busy_clear", 64'(busy),      64'd0);
    check("single.btn_hold",   pad_btn,        64'h0000_0000_0000_A5F0);

    // Pending coalescing: three requests yield exactly two polls back to back.
    poll_req = 1'b1; tick(); poll_req = 1'b0;
    repeat (9) tick();
    poll_req = 1'b1; tick(); poll_req = 1'b0;
    repeat (9) tick();
    poll_req = 1'b1; tick(); poll_req = 1'b0;
    nv = 0; v1 = -1; r2 = -1; prev = pad_latch;
    for (int t = 0; t < 300; t++) begin
      tick();
      if (pad_valid) begin
        nv++;
        if (v1 < 0) v1 = t;
      end
      if (pad_latch && !prev && v1 >= 0 && r2 < 0) r2 = t;
      prev = pad_latch;
    end
    check("coalesce.valid_count", 64'(nv), 64'd2);
    check("coalesce.relatch_gap", 64'(r2 - v1), 64'd1);
    check("coalesce.idle_after",  64'(busy), 64'd0);

    // Auto polling at a 200-cycle period.
    auto_enable = 1'b1;
    wait_rise(400, n);
    check("auto.first", 64'(n), 64'd200);
    wait_rise(400, n);
    check("auto.period1", 64'(n), 64'd200);
    wait_rise(400, n);
    check("auto.period2", 64'(n), 64'd200);
    wait_valid(100);
    auto_enable = 1'b0;
    wait_rise(450, n);
    check("auto.disabled", 64'(n), 64'hFFFF_FFFF_FFFF_FFFF);
    auto_enable = 1'b1;
    wait_rise(400, n);
    check("auto.reenable", 64'(n), 64'd200);
    wait_valid(100);
    auto_enable = 1'b0;
    repeat (3) tick();

    // Reset during bit 7 of the shift.
    poll_req = 1'b1; tick(); poll_req = 1'b0;
    repeat (33) tick();
    check("midreset.in_low_phase", 64'(pad_clk), 64'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_outputs("midreset");
    nv = 0;
    for (int t = 0; t < 100; t++) begin
      tick();
      if (pad_valid || busy) nv++;
    end
    check("midreset.no_valid", 64'(nv), 64'd0);
    pad_val = ~16'h3C5A;
    run_poll(lat, nl, nf, nlow);
    check("midreset.repoll_lat", 64'(lat), 64'd68);
    check("midreset.repoll_btn", pad_btn, 64'h0000_0000_0000_3C5A);

    // Polarity: all lines high reads as nothing pressed when active-low.
    pad_val = 16'hFFFF;
    run_poll(lat, nl, nf, nlow);
    check("polarity.low_lat", 64'(lat),  64'd68);
    check("polarity.low_btn", pad_btn,   64'd0);

    // Active-high, 2 ports x 12 bits.
    poll_req2 = 1'b1; tick(); poll_req2 = 1'b0;
    check("polarity.high_busy", 64'(busy2), 64'd1);
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (pad_valid2) begin
        lat = k;
        break;
      end
    end
    check("polarity.high_lat", 64'(lat),      64'd52);
    check("polarity.high_btn", 64'(pad_btn2), 64'h0000_0000_00FF_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
